point_cloud_bbox: RTL and testbench
===================================

// Module: point_cloud_bbox
// PURPOSE
//  Streaming pre-pass upstream of octant_core. It accepts the point cloud once
//  and tracks per-axis min/max to form the root bounding box. It then computes
//  the box midpoint and presents near_bottom_left / far_top_right / mid_point
//  in the packed {x,y,z,pad} 64-bit format that octant_core consumes.
// PARAMETERS
//  COORD_W   16  signed coordinate width per axis (lane width in packed word)
//  NUM_AXES  3   active axes (x,y,z); 4th lane is pad, always driven 0
//  CNT_W     16  point counter / cloud-size width
// PORTS
//  i_clk               in   1        single clock, rising edge
//  i_rst_n             in   1        asynchronous active-low reset
//  i_start             in   1        begin new pass (honoured only in IDLE)
//  i_point_cloud_size  in   CNT_W    points in pass, sampled on accepted i_start
//  i_point_valid       in   1        i_point carries a point
//  i_point             in   64       {x[63:48],y[47:32],z[31:16],pad[15:0]} signed
//  o_point_ready       out  1        high in ACCUM; point accepted on valid&&ready
//  o_near_bottom_left  out  64       packed per-axis minimum, pad=0
//  o_far_top_right     out  64       packed per-axis maximum, pad=0
//  o_mid_point         out  64       packed per-axis (min+max)>>>1, pad=0
//  o_bbox_valid        out  1        level: outputs hold a completed result
//  o_done              out  1        one-cycle pulse on completion
//  o_busy              out  1        high in ACCUM and MID
//  o_point_count       out  CNT_W    points accepted in current/last pass
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0; min/max regs cleared.
//  FSM: IDLE -> ACCUM -> MID -> DONE -> IDLE.
//   IDLE:  i_start=1 latches size, count<=0, min<=+2^(W-1)-1, max<=-2^(W-1),
//          o_bbox_valid<=0. size!=0 -> ACCUM; size==0 -> MID, min/max<=0.
//   ACCUM: on valid&&ready, update each axis: min<=smin(min,p), max<=smax(max,p).
//          Comparisons are signed. count++. Accepting point number size
//          (count==size-1) -> MID. valid low: hold state, no update.
//   MID:   one cycle; register the three 64-bit outputs from min/max. mid uses a
//          COORD_W+1 sign-extended sum, arithmetic shift right 1 (floor), then
//          truncated to COORD_W. -> DONE.
//   DONE:  o_done=1 for exactly this cycle; o_bbox_valid<=1. -> IDLE.
//  Latency: o_done is high in the cycle after the 2nd rising edge following the
//   edge that accepted the final point. Outputs are valid from o_done onward.
//  Outputs hold the last result until the next accepted i_start clears
//   o_bbox_valid. Output values are only rewritten in MID.
//  i_start outside IDLE is ignored. A point presented outside ACCUM is not
//   accepted. Input pad lane is ignored.
//  Equal points: min==max and mid==min. A single-point cloud is legal.
//  Mid-pass reset abandons the pass. After release the block is in IDLE with
//   o_bbox_valid=0.
// STRUCTURE
//  Shared package octree_pkg: COORD_W, lane offsets (X_MSB=63,Y_MSB=47,Z_MSB=31),
//   FSM state localparams, packing/unpacking functions for {x,y,z,pad}.
//  One sub-module bbox_axis_tracker: one signed min/max pair with init/update
//   enables, instantiated NUM_AXES times. Midpoint and packing stay in the top.
// TESTING
//  1 start size=3; points (-10113,-7972,-441),(5557,7985,315),(257,-42,-155)
//    -> nbl={-10113,-7972,-441,0}, ftr={5557,7985,315,0}, mid={-2278,6,-63,0}
//  2 valid gaps: same 3 points with valid low 2 cycles between each -> same
//    result; o_point_count=3; o_done exactly one pulse
//  3 size=1, point (-5,7,-1) -> nbl=ftr=mid={-5,7,-1,0}; size=0 -> all-zero
//    outputs; o_done 2 cycles after start
//  4 extremes: points (-32768,32767,0),(32767,-32768,0) -> mid={-1,-1,0,0}
//    (floor), no overflow
//  5 i_start pulsed in ACCUM -> ignored, count continues. Reset asserted after
//    2 of 3 points -> outputs 0, IDLE. A new pass after reset is correct.
//  6 back-to-back passes: the second start clears o_bbox_valid. The first
//    result holds until the second pass reaches MID.

Source files
------------

// File: rtl/octree_pkg.sv
// Shared definitions for the octree front end: the packed {x,y,z,pad} point
// layout, the bounding-box pass states and lane pack/unpack helpers.
package octree_pkg;

  localparam int COORD_W  = 16;
  localparam int NUM_AXES = 3;
  localparam int CNT_W    = 16;

  localparam int X_MSB = 63;
  localparam int Y_MSB = 47;
  localparam int Z_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_MID   = 2'd2,
    ST_DONE  = 2'd3
  } bbox_state_e;

  // Axis 0 is x, 1 is y, 2 is z; the pad lane is never extracted.
  function automatic logic [COORD_W-1:0] lane_of(input logic [63:0] word, input int axis);
    logic [COORD_W-1:0] lane;
    case (axis)
      0:       lane = word[X_MSB -: COORD_W];
      1:       lane = word[Y_MSB -: COORD_W];
      default: lane = word[Z_MSB -: COORD_W];
    endcase
    return lane;
  endfunction

  function automatic logic [63:0] pack_point(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y,
                                             input logic [COORD_W-1:0] z);
    return {x, y, z, {COORD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/bbox_axis_tracker.sv
// Signed running minimum/maximum of one coordinate axis. The init value wins
// over an update presented in the same cycle.
module bbox_axis_tracker
  import octree_pkg::*;
#(
  parameter int W = octree_pkg::COORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         init_zero,
  input  logic         update,
  input  logic [W-1:0] coord,
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o
);

  logic signed [W-1:0] min_q, min_d;
  logic signed [W-1:0] max_q, max_d;
  logic signed [W-1:0] coord_s;

  assign coord_s = coord;

  // Init seeds min at the most positive and max at the most negative value
  // so the first accepted point overwrites both.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (init) begin
      if (init_zero) begin
        min_d = '0;
        max_d = '0;
      end else begin
        min_d = {1'b0, {(W-1){1'b1}}};
        max_d = {1'b1, {(W-1){1'b0}}};
      end
    end else if (update) begin
      if (coord_s < min_q) min_d = coord_s;
      if (coord_s > max_q) max_d = coord_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/point_cloud_bbox.sv
// Streaming pre-pass that forms the root bounding box and its midpoint of a
// point cloud, presented in the packed {x,y,z,pad} format octant_core uses.
module point_cloud_bbox #(
  parameter int COORD_W  = octree_pkg::COORD_W,
  parameter int NUM_AXES = octree_pkg::NUM_AXES,
  parameter int CNT_W    = octree_pkg::CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_point_cloud_size,
  input  logic             i_point_valid,
  input  logic [63:0]      i_point,
  output logic             o_point_ready,
  output logic [63:0]      o_near_bottom_left,
  output logic [63:0]      o_far_top_right,
  output logic [63:0]      o_mid_point,
  output logic             o_bbox_valid,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_point_count
);
  import octree_pkg::*;

  bbox_state_e state_q, state_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0] nbl_q, nbl_d;
  logic [63:0] ftr_q, ftr_d;
  logic [63:0] mid_q, mid_d;
  logic bbox_valid_q, bbox_valid_d;
  logic done_q, done_d;

  logic trk_init, trk_init_zero, trk_update;
  logic [COORD_W-1:0] axis_min [NUM_AXES];
  logic [COORD_W-1:0] axis_max [NUM_AXES];
  logic [COORD_W-1:0] axis_mid [NUM_AXES];

  logic unused_pad;
  assign unused_pad = ^i_point[COORD_W-1:0];

  // The one-bit-wider sum keeps extreme coordinates from overflowing; taking
  // bits [W:1] is the floor shift followed by truncation back to W bits.
  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    logic [COORD_W:0] sum;

    bbox_axis_tracker #(.W(COORD_W)) u_tracker (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .init      (trk_init),
      .init_zero (trk_init_zero),
      .update    (trk_update),
      .coord     (lane_of(i_point, a)),
      .min_o     (axis_min[a]),
      .max_o     (axis_max[a])
    );

    assign sum = {axis_min[a][COORD_W-1], axis_min[a]} + {axis_max[a][COORD_W-1], axis_max[a]};
    assign axis_mid[a] = sum[COORD_W:1];
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    count_d       = count_q;
    nbl_d         = nbl_q;
    ftr_d         = ftr_q;
    mid_d         = mid_q;
    bbox_valid_d  = bbox_valid_q;
    done_d        = 1'b0;
    trk_init      = 1'b0;
    trk_init_zero = 1'b0;
    trk_update    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          size_d       = i_point_cloud_size;
          count_d      = '0;
          bbox_valid_d = 1'b0;
          trk_init     = 1'b1;
          if (i_point_cloud_size == '0) begin
            trk_init_zero = 1'b1;
            state_d       = ST_MID;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (i_point_valid) begin
          trk_update = 1'b1;
          count_d    = count_q + 1'b1;
          if (count_q == size_q - 1'b1) state_d = ST_MID;
        end
      end
      ST_MID: begin
        nbl_d   = pack_point(axis_min[0], axis_min[1], axis_min[2]);
        ftr_d   = pack_point(axis_max[0], axis_max[1], axis_max[2]);
        mid_d   = pack_point(axis_mid[0], axis_mid[1], axis_mid[2]);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d       = 1'b1;
        bbox_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      size_q       <= '0;
      count_q      <= '0;
      nbl_q        <= '0;
      ftr_q        <= '0;
      mid_q        <= '0;
      bbox_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      count_q      <= count_d;
      nbl_q        <= nbl_d;
      ftr_q        <= ftr_d;
      mid_q        <= mid_d;
      bbox_valid_q <= bbox_valid_d;
      done_q       <= done_d;
    end
  end

  assign o_point_ready      = (state_q == ST_ACCUM);
  assign o_busy             = (state_q == ST_ACCUM) || (state_q == ST_MID);
  assign o_near_bottom_left = nbl_q;
  assign o_far_top_right    = ftr_q;
  assign o_mid_point        = mid_q;
  assign o_bbox_valid       = bbox_valid_q;
  assign o_done             = done_q;
  assign o_point_count      = count_q;

endmodule

// File: tb/tb_point_cloud_bbox.sv
// Directed bench for point_cloud_bbox: a table of whole passes with
// hand-computed boxes, plus sequences for gaps, ignored starts, reset and
// back-to-back passes.
module tb_point_cloud_bbox;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_point_cloud_size = '0;
  logic        i_point_valid = 1'b0;
  logic [63:0] i_point = '0;
  logic        o_point_ready;
  logic [63:0] o_near_bottom_left;
  logic [63:0] o_far_top_right;
  logic [63:0] o_mid_point;
  logic        o_bbox_valid;
  logic        o_done;
  logic        o_busy;
  logic [15:0] o_point_count;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0]      size;
    int               npts;
    logic [2:0][63:0] pts;
    logic [63:0]      expNbl;
    logic [63:0]      expFtr;
    logic [63:0]      expMid;
  } vec_t;

  vec_t vecs [6];

  point_cloud_bbox dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_start            (i_start),
    .i_point_cloud_size (i_point_cloud_size),
    .i_point_valid      (i_point_valid),
    .i_point            (i_point),
    .o_point_ready      (o_point_ready),
    .o_near_bottom_left (o_near_bottom_left),
    .o_far_top_right    (o_far_top_right),
    .o_mid_point        (o_mid_point),
    .o_bbox_valid       (o_bbox_valid),
    .o_done             (o_done),
    .o_busy             (o_busy),
    .o_point_count      (o_point_count)
  );

  always #5 i_clk = ~i_clk;

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] pk(input int x, input int y, input int z);
    logic [15:0] xs, ys, zs;
    xs = x[15:0];
    ys = y[15:0];
    zs = z[15:0];
    return {xs, ys, zs, 16'h0000};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic setVec(input int idx, input int size, input logic [63:0] p0, input logic [63:0] p1,
                        input logic [63:0] p2, input logic [63:0] nbl, input logic [63:0] ftr,
                        input logic [63:0] mid);
    vecs[idx].size   = size[15:0];
    vecs[idx].npts   = size;
    vecs[idx].pts[0] = p0;
    vecs[idx].pts[1] = p1;
    vecs[idx].pts[2] = p2;
    vecs[idx].expNbl = nbl;
    vecs[idx].expFtr = ftr;
    vecs[idx].expMid = mid;
  endtask

  // Runs one full pass with 'gap' idle cycles between points; lat counts
  // negedges from the release of the last point (or start) to o_done.
  task automatic applyStimulus(input vec_t v, input int gap, output int lat);
    @(negedge i_clk);
    i_start = 1'b1;
    i_point_cloud_size = v.size;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < v.npts; i++) begin
      i_point_valid = 1'b0;
      if (i > 0) repeat (gap) @(negedge i_clk);
      i_point_valid = 1'b1;
      i_point = v.pts[i];
      @(negedge i_clk);
    end
    i_point_valid = 1'b0;
    lat = 0;
    while (!o_done && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v, input int gap, input string tag);
    int lat;
    applyStimulus(v, gap, lat);
    checkOutput({tag, " latency"}, 64'(lat), 64'd2);
    checkOutput({tag, " nbl"}, o_near_bottom_left, v.expNbl);
    checkOutput({tag, " ftr"}, o_far_top_right, v.expFtr);
    checkOutput({tag, " mid"}, o_mid_point, v.expMid);
    checkOutput({tag, " count"}, 64'(o_point_count), 64'(v.size));
    checkOutput({tag, " valid"}, 64'(o_bbox_valid), 64'd1);
    @(negedge i_clk);
    checkOutput({tag, " done pulse"}, 64'(o_done), 64'd0);
    checkOutput({tag, " valid hold"}, 64'(o_bbox_valid), 64'd1);
  endtask

  initial begin
    int lat;
    setVec(0, 3, pk(-10113, -7972, -441), pk(5557, 7985, 315), pk(257, -42, -155),
           pk(-10113, -7972, -441), pk(5557, 7985, 315), pk(-2278, 6, -63));
    setVec(1, 1, pk(-5, 7, -1), 64'd0, 64'd0, pk(-5, 7, -1), pk(-5, 7, -1), pk(-5, 7, -1));
    setVec(2, 0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    setVec(3, 2, pk(-32768, 32767, 0), pk(32767, -32768, 0), 64'd0,
           pk(-32768, -32768, 0), pk(32767, 32767, 0), pk(-1, -1, 0));
    setVec(4, 2, pk(-3, 4, 1), pk(0, 1, 2), 64'd0, pk(-3, 1, 1), pk(0, 4, 2), pk(-2, 2, 1));
    setVec(5, 3, pk(100, -200, 300) | 64'hBEEF, pk(100, -200, 300) | 64'h1234,
           pk(100, -200, 300) | 64'hFFFF, pk(100, -200, 300), pk(100, -200, 300),
           pk(100, -200, 300));

    // Reset state while reset is held.
    repeat (2) @(negedge i_clk);
    checkOutput("reset nbl", o_near_bottom_left, 64'd0);
    checkOutput("reset ftr", o_far_top_right, 64'd0);
    checkOutput("reset mid", o_mid_point, 64'd0);
    checkOutput("reset flags", {60'd0, o_bbox_valid, o_done, o_busy, o_point_ready}, 64'd0);
    checkOutput("reset count", 64'(o_point_count), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("idle ready", 64'(o_point_ready), 64'd0);

    for (int i = 0; i < 6; i++) runVector(vecs[i], 0, $sformatf("vec%0d", i));

    // Idle cycles with valid high must not be accepted.
    i_point_valid = 1'b1;
    i_point = pk(1, 1, 1);
    repeat (2) @(negedge i_clk);
    i_point_valid = 1'b0;
    checkOutput("idle point count", 64'(o_point_count), 64'd3);
    checkOutput("idle point nbl", o_near_bottom_left, vecs[5].expNbl);

    runVector(vecs[0], 2, "gaps");

    // Start pulsed in ACCUM with a different size must be ignored.
    @(negedge i_clk);
    i_start = 1'b1;
    i_point_cloud_size = 16'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    i_point_valid = 1'b1;
    i_point = vecs[0].pts[0];
    @(negedge i_clk);
    i_point = vecs[0].pts[1];
    i_start = 1'b1;
    i_point_cloud_size = 16'd1;
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("ignstart count", 64'(o_point_count), 64'd2);
    checkOutput("ignstart busy", 64'(o_busy), 64'd1);
    i_point = vecs[0].pts[2];
    @(negedge i_clk);
    i_point_valid = 1'b0;
    checkOutput("ignstart count3", 64'(o_point_count), 64'd3);
    lat = 0;
    while (!o_done && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    checkOutput("ignstart latency", 64'(lat), 64'd2);
    checkOutput("ignstart mid", o_mid_point, vecs[0].expMid);
    checkOutput("ignstart ftr", o_far_top_right, vecs[0].expFtr);

    // Reset after two of three points abandons the pass.
    @(negedge i_clk);
    i_start = 1'b1;
    i_point_cloud_size = 16'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    i_point_valid = 1'b1;
    i_point = vecs[4].pts[0];
    @(negedge i_clk);
    i_point = vecs[4].pts[1];
    @(negedge i_clk);
    i_point_valid = 1'b0;
    checkOutput("prereset count", 64'(o_point_count), 64'd2);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset nbl", o_near_bottom_left, 64'd0);
    checkOutput("midreset mid", o_mid_point, 64'd0);
    checkOutput("midreset count", 64'(o_point_count), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("postreset flags", {60'd0, o_bbox_valid, o_done, o_busy, o_point_ready}, 64'd0);
    runVector(vecs[4], 0, "postreset");

    // Back-to-back: previous result holds until the new pass reaches MID.
    runVector(vecs[0], 0, "b2b first");
    i_start = 1'b1;
    i_point_cloud_size = vecs[4].size;
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("b2b valid cleared", 64'(o_bbox_valid), 64'd0);
    checkOutput("b2b hold nbl", o_near_bottom_left, vecs[0].expNbl);
    i_point_valid = 1'b1;
    i_point = vecs[4].pts[0];
    @(negedge i_clk);
    i_point = vecs[4].pts[1];
    @(negedge i_clk);
    i_point_valid = 1'b0;
    checkOutput("b2b hold in mid", o_mid_point, vecs[0].expMid);
    @(negedge i_clk);
    checkOutput("b2b new nbl", o_near_bottom_left, vecs[4].expNbl);
    checkOutput("b2b new mid", o_mid_point, vecs[4].expMid);
    checkOutput("b2b done early", 64'(o_done), 64'd0);
    @(negedge i_clk);
    checkOutput("b2b done", 64'(o_done), 64'd1);
    checkOutput("b2b valid", 64'(o_bbox_valid), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
